// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch-side and execute-side handshake bundle for decode_stage
interface decode_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [6:0]      out_opcode;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic            out_rd_we;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
               out_funct3, out_funct7, out_imm, out_fmt, out_rd_we, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
               out_funct3, out_funct7, out_imm, out_fmt, out_rd_we, out_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered RV32I decode stage with two-entry skid buffer and flush
module decode_stage #(
    parameter int XLEN = 32,
    parameter bit SKID = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    decode_stage_if.slave bus
);
    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            rd_we;
        logic            illegal;
    } dec_t;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_ONE,
        S_FULL
    } state_t;

    logic [31:0]        instr;
    logic [2:0]         fmt;
    logic signed [31:0] imm32;
    dec_t               dec;

    state_t state_q, state_d;
    dec_t   m_q, k_q;
    logic   in_ready_q;
    logic   accept;
    logic   load_m, load_k, move_k;

    assign instr = bus.in_instr;

    // Decode happens before the buffer so only the compact bundle is stored.
    always_comb begin
        dec   = '0;
        imm32 = '0;
        case (instr[6:0])
            7'b0110011:                                       fmt = FMT_R;
            7'b0000011, 7'b0010011, 7'b1100111,
            7'b1110011, 7'b0001111:                           fmt = FMT_I;
            7'b0100011:                                       fmt = FMT_S;
            7'b1100011:                                       fmt = FMT_B;
            7'b0110111, 7'b0010111:                           fmt = FMT_U;
            7'b1101111:                                       fmt = FMT_J;
            default:                                          fmt = FMT_ILL;
        endcase
        if (instr[1:0] != 2'b11) begin
            fmt = FMT_ILL;
        end

        dec.pc  = bus.in_pc;
        dec.fmt = fmt;
        case (fmt)
            FMT_R: begin
                dec.opcode = instr[6:0];
                dec.rd     = instr[11:7];
                dec.rs1    = instr[19:15];
                dec.rs2    = instr[24:20];
                dec.funct3 = instr[14:12];
                dec.funct7 = instr[31:25];
            end
            FMT_I: begin
                dec.opcode = instr[6:0];
                dec.rd     = instr[11:7];
                dec.rs1    = instr[19:15];
                dec.funct3 = instr[14:12];
                imm32      = {{20{instr[31]}}, instr[31:20]};
            end
            FMT_S: begin
                dec.opcode = instr[6:0];
                dec.rs1    = instr[19:15];
                dec.rs2    = instr[24:20];
                dec.funct3 = instr[14:12];
                imm32      = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            FMT_B: begin
                dec.opcode = instr[6:0];
                dec.rs1    = instr[19:15];
                dec.rs2    = instr[24:20];
                dec.funct3 = instr[14:12];
                imm32      = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            FMT_U: begin
                dec.opcode = instr[6:0];
                dec.rd     = instr[11:7];
                imm32      = {instr[31:12], 12'b0};
            end
            FMT_J: begin
                dec.opcode = instr[6:0];
                dec.rd     = instr[11:7];
                imm32      = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
        dec.imm   = XLEN'(imm32);
        dec.rd_we = ((fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_U) || (fmt == FMT_J))
                    && (dec.rd != 5'd0);
    end

    assign bus.out_valid = (state_q != S_EMPTY);
    assign bus.in_ready  = SKID ? in_ready_q : (!bus.out_valid || bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d = state_q;
        load_m  = 1'b0;
        load_k  = 1'b0;
        move_k  = 1'b0;
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        state_d = S_ONE;
                        load_m  = 1'b1;
                    end
                end
                S_ONE: begin
                    if (accept && bus.out_ready) begin
                        load_m = 1'b1;
                    end else if (accept && SKID) begin
                        state_d = S_FULL;
                        load_k  = 1'b1;
                    end else if (bus.out_ready) begin
                        state_d = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (bus.out_ready) begin
                        state_d = S_ONE;
                        move_k  = 1'b1;
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != S_FULL);
        end
    end

    // Flush also zeroes M so a discarded entry never lingers on the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q <= '0;
            k_q <= '0;
        end else begin
            if (flush) begin
                m_q <= '0;
            end else if (move_k) begin
                m_q <= k_q;
            end else if (load_m) begin
                m_q <= dec;
            end
            if (load_k) begin
                k_q <= dec;
            end
        end
    end

    assign bus.out_pc      = m_q.pc;
    assign bus.out_opcode  = m_q.opcode;
    assign bus.out_rd      = m_q.rd;
    assign bus.out_rs1     = m_q.rs1;
    assign bus.out_rs2     = m_q.rs2;
    assign bus.out_funct3  = m_q.funct3;
    assign bus.out_funct7  = m_q.funct7;
    assign bus.out_imm     = m_q.imm;
    assign bus.out_fmt     = m_q.fmt;
    assign bus.out_rd_we   = m_q.rd_we;
    assign bus.out_illegal = m_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard testbench for decode_stage
module tb_decode_stage;
    typedef logic [100:0] bundle_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    int   errors = 0;
    int   checks = 0;
    bundle_t sb[$];
    bundle_t prev_obs;
    logic    prev_stall = 1'b0;

    decode_stage_if #(.XLEN(32)) bus();

    decode_stage #(.XLEN(32), .SKID(1'b1)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic bundle_t observed();
        return {bus.out_pc, bus.out_opcode, bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_funct3,
                bus.out_funct7, bus.out_imm, bus.out_fmt, bus.out_rd_we, bus.out_illegal};
    endfunction

    // Reference decoder built from shifts and masks.
    function automatic bundle_t model(input logic [31:0] i, input logic [31:0] pc);
        logic [6:0]  op = 7'd0;
        logic [4:0]  rd = 5'd0, rs1 = 5'd0, rs2 = 5'd0;
        logic [2:0]  f3 = 3'd0, fmt;
        logic [6:0]  f7 = 7'd0;
        logic [31:0] imm = 32'd0;
        logic [31:0] sgn = i[31] ? 32'hFFFFFFFF : 32'h0;
        logic        we = 1'b0, ill = 1'b0;
        case (i[6:0])
            7'h33:                               fmt = 3'd0;
            7'h03, 7'h13, 7'h67, 7'h73, 7'h0F:   fmt = 3'd1;
            7'h23:                               fmt = 3'd2;
            7'h63:                               fmt = 3'd3;
            7'h37, 7'h17:                        fmt = 3'd4;
            7'h6F:                               fmt = 3'd5;
            default:                             fmt = 3'd7;
        endcase
        if (fmt != 3'd7) begin
            op = i[6:0];
            if (fmt inside {3'd0, 3'd1, 3'd4, 3'd5}) rd = i[11:7];
            if (fmt inside {3'd0, 3'd1, 3'd2, 3'd3}) begin rs1 = i[19:15]; f3 = i[14:12]; end
            if (fmt inside {3'd0, 3'd2, 3'd3}) rs2 = i[24:20];
            if (fmt == 3'd0) f7 = i[31:25];
            we = (fmt inside {3'd0, 3'd1, 3'd4, 3'd5}) && (rd != 5'd0);
        end else begin
            ill = 1'b1;
        end
        case (fmt)
            3'd1: imm = (sgn & 32'hFFFFF000) | (i >> 20);
            3'd2: imm = (sgn & 32'hFFFFF000) | ((i >> 20) & 32'hFE0) | ((i >> 7) & 32'h1F);
            3'd3: imm = (sgn & 32'hFFFFF000) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
            3'd4: imm = i & 32'hFFFFF000;
            3'd5: imm = (sgn & 32'hFFF00000) | (i & 32'h000FF000) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
            default: imm = 32'd0;
        endcase
        return {pc, op, rd, rs1, rs2, f3, f7, imm, fmt, we, ill};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r = $urandom();
        logic [6:0] ops [11] = '{7'h33, 7'h03, 7'h13, 7'h67, 7'h73, 7'h0F, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
        int p = $urandom_range(0, 11);
        if (p == 11) return r;
        return {r[31:7], ops[p]};
    endfunction

    // Scoreboard: push on accept, pop and compare on each output transfer.
    always @(negedge clk) begin
        bundle_t obs, exp;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            obs = observed();
            if (prev_stall && bus.out_valid) begin
                checks++;
                if (obs !== prev_obs) begin
                    errors++;
                    $display("FAIL hold_stable: got %h, required %h", obs, prev_obs);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got %h, required no entry", obs);
                end else begin
                    exp = sb.pop_front();
                    if (obs !== exp) begin
                        errors++;
                        $display("FAIL scoreboard: got %h, required %h", obs, exp);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready && !flush)
                sb.push_back(model(bus.in_instr, bus.in_pc));
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_obs   = obs;
        end
    end

    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        bus.in_pc    = pc;
        @(negedge clk);
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            errors++;
            checks++;
            $display("FAIL send_timeout: in_ready=%0b, required 1", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        while ((sb.size() != 0 || bus.out_valid) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (sb.size() != 0 || bus.out_valid) begin
            errors++;
            $display("FAIL drain: pending=%0d out_valid=%0b, required 0 and 0", sb.size(), bus.out_valid);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b, required 0", bus.out_valid); end
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b, required 1", bus.in_ready); end
        checks++;
        if (observed() !== '0) begin errors++; $display("FAIL reset_outputs: got %h, required 0", observed()); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_decode();
        logic [31:0] ins [8] = '{32'hFFF10093, 32'h00532423, 32'hFE000EE3, 32'h123451B7,
                                 32'hFFFFFFFF, 32'h402081B3, 32'hFF9FF0EF, 32'h00000010};
        logic [29:0] fld [8] = '{{5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 3'd1, 1'b1, 1'b0},
                                 {5'd0, 5'd6, 5'd5, 3'd2, 7'd0, 3'd2, 1'b0, 1'b0},
                                 {5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 3'd3, 1'b0, 1'b0},
                                 {5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 3'd4, 1'b1, 1'b0},
                                 {5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 3'd7, 1'b0, 1'b1},
                                 {5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 3'd0, 1'b1, 1'b0},
                                 {5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 3'd5, 1'b1, 1'b0},
                                 {5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 3'd7, 1'b0, 1'b1}};
        logic [31:0] imm [8] = '{32'hFFFFFFFF, 32'h8, 32'hFFFFFFFC, 32'h12345000,
                                 32'h0, 32'h0, 32'hFFFFFFF8, 32'h0};
        logic [29:0] got;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            send(ins[k], 32'h100 + 32'(k * 4));
            @(negedge clk);
            got = {bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_funct3, bus.out_funct7,
                   bus.out_fmt, bus.out_rd_we, bus.out_illegal};
            checks++;
            if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL latency[%0d]: out_valid=%0b, required 1", k, bus.out_valid); end
            checks++;
            if (got !== fld[k]) begin errors++; $display("FAIL fields[%0d]: got %h, required %h", k, got, fld[k]); end
            checks++;
            if (bus.out_imm !== imm[k]) begin errors++; $display("FAIL imm[%0d]: got %h, required %h", k, bus.out_imm, imm[k]); end
            checks++;
            if (bus.out_pc !== 32'h100 + 32'(k * 4)) begin errors++; $display("FAIL pc[%0d]: got %h, required %h", k, bus.out_pc, 32'h100 + 32'(k * 4)); end
            @(posedge clk); #1;
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int stalls = 0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 24; k++) begin
            bus.in_valid = 1'b1;
            bus.in_instr = rand_instr();
            bus.in_pc    = 32'h1000 + 32'(k * 4);
            @(negedge clk);
            if (!bus.in_ready) stalls++;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (stalls != 0) begin errors++; $display("FAIL throughput: stalls=%0d, required 0", stalls); end
        drain();
    endtask

    task automatic test_backpressure();
        logic [31:0] pa = 32'h2000, pb = 32'h2004, pc = 32'h2008;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_instr = 32'hFFF10093; bus.in_pc = pa;
        @(negedge clk);
        @(posedge clk); #1;
        bus.in_instr = 32'h00532423; bus.in_pc = pb;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_second_accept: in_ready=%0b, required 1", bus.in_ready); end
        @(posedge clk); #1;
        bus.in_instr = 32'h123451B7; bus.in_pc = pc;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (bus.in_ready !== 1'b0 || bus.out_pc !== pa) begin
                errors++;
                $display("FAIL bp_full[%0d]: in_ready=%0b pc=%h, required 0 and %h", k, bus.in_ready, bus.out_pc, pa);
            end
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1 || bus.out_pc !== pb) begin
            errors++;
            $display("FAIL bp_release: valid=%0b ready=%0b pc=%h, required 1 1 %h", bus.out_valid, bus.in_ready, bus.out_pc, pb);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== pc) begin
            errors++;
            $display("FAIL bp_no_bubble: valid=%0b pc=%h, required 1 %h", bus.out_valid, bus.out_pc, pc);
        end
        @(posedge clk); #1;
        drain();
    endtask

    task automatic test_flush();
        int seen = 0;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_instr = 32'h00000013; bus.in_pc = 32'h3000;
        @(negedge clk); @(posedge clk); #1;
        bus.in_pc = 32'h3004;
        @(negedge clk); @(posedge clk); #1;
        bus.in_instr = 32'hDEADB0B7; bus.in_pc = 32'h3BAD;
        flush = 1'b1;
        @(negedge clk); @(posedge clk); #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_full: valid=%0b ready=%0b, required 0 1", bus.out_valid, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL flush_leak: valid cycles=%0d, required 0", seen); end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_instr = 32'h00100093; bus.in_pc = 32'h3100;
        @(negedge clk); @(posedge clk); #1;
        bus.in_instr = 32'h00200113; bus.in_pc = 32'h3104;
        flush = 1'b1;
        @(negedge clk); @(posedge clk); #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_one: valid=%0b, required 0", bus.out_valid); end
        @(posedge clk); #1;
        drain();
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        send(32'hFFF10093, 32'h4000);
        @(negedge clk);
        #2 rst = 1'b1;
        sb.delete();
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || observed() !== '0) begin
            errors++;
            $display("FAIL async_reset: valid=%0b ready=%0b out=%h, required 0 1 0", bus.out_valid, bus.in_ready, observed());
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        send(32'h00532423, 32'h4100);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_rs1 !== 5'd6 || bus.out_pc !== 32'h4100) begin
            errors++;
            $display("FAIL post_reset: valid=%0b rs1=%0d pc=%h, required 1 6 4100", bus.out_valid, bus.out_rs1, bus.out_pc);
        end
        @(posedge clk); #1;
        drain();
    endtask

    task automatic test_random_backpressure();
        int n;
        logic acc;
        for (int k = 0; k < 40; k++) begin
            bus.in_valid = 1'b1;
            bus.in_instr = rand_instr();
            bus.in_pc    = 32'h5000 + 32'(k * 4);
            n = 0;
            do begin
                @(negedge clk);
                acc = bus.in_ready;
                @(posedge clk); #1;
                bus.out_ready = 1'($urandom_range(0, 1));
                n++;
            end while (!acc && n < 40);
            if (!acc) begin
                errors++;
                checks++;
                $display("FAIL random_timeout[%0d]: in_ready=%0b, required 1", k, acc);
            end
        end
        bus.in_valid = 1'b0;
        drain();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_instr  = 32'd0;
        bus.in_pc     = 32'd0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_decode();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random_backpressure();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised RV32I instruction-decode stage sitting between fetch and register-read/execute. It decodes all base-ISA formats (R/I/S/B/U/J), zeroes the fields a format does not use, and generates the sign-extended immediate. Results are buffered behind a valid/ready handshake with a two-entry skid buffer, so fetch-side `in_ready` is a registered signal. It supports a synchronous pipeline flush for branch redirects.

## Interface
- `XLEN`, 32: datapath width for `in_pc`, `out_pc` and `out_imm`; must be ≥ 32.
- `SKID`, 1: 1 = two-entry skid buffer with registered `in_ready`; 0 = single entry with `in_ready = !out_valid || out_ready`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `flush` input 1: synchronous; discards all buffered entries.
- `in_valid` input 1: `in_instr`/`in_pc` are valid.
- `in_ready` output 1: stage can accept an instruction this cycle.
- `in_instr` input 32: raw instruction word.
- `in_pc` input XLEN: PC of `in_instr`.
- `out_valid` output 1: decoded entry presented.
- `out_ready` input 1: consumer accepts the entry.
- `out_pc` output XLEN: PC of the presented entry.
- `out_opcode` output 7: `instr[6:0]`.
- `out_rd`, `out_rs1`, `out_rs2` output 5 each: register indices; 0 when the format has no such field.
- `out_funct3` output 3: `instr[14:12]`; 0 for U/J.
- `out_funct7` output 7: `instr[31:25]` for R-type only, else 0.
- `out_imm` output XLEN: sign-extended immediate; 0 for R-type and illegal.
- `out_fmt` output 3: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal.
- `out_rd_we` output 1: 1 for R, I, U and J formats with `rd != 0`.
- `out_illegal` output 1: unsupported opcode, or `instr[1:0] != 2'b11`.

## Operation
- Opcode map:
  - R: 0110011.
  - I: 0000011, 0010011, 1100111, 1110011, 0001111.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - Any other opcode is illegal.
- Immediates, with `s` = sign-extend from `instr[31]` to XLEN:
  - I: `s(instr[31:20])`.
  - S: `s({instr[31:25], instr[11:7]})`.
  - B: `s({instr[31], instr[7], instr[30:25], instr[11:8], 0})`.
  - U: `s({instr[31:12], 12'b0})`.
  - J: `s({instr[31], instr[19:12], instr[20], instr[30:21], 0})`.
- Illegal entries still flow through the stage, so the trap is taken in order: `out_illegal=1`, `out_fmt=7`, all field outputs 0, `out_rd_we=0`, `out_pc` kept.
- Decode is combinational on the input side; the decoded bundle is what gets registered, not the raw word.
- Buffer state machine (SKID=1): main entry M, skid entry K.
  - EMPTY to ONE: on accept.
  - ONE to FULL: on accept while `out_ready=0`.
  - ONE to ONE: on accept while `out_ready=1` (M replaced).
  - ONE to EMPTY: on `out_ready` with no accept.
  - FULL to ONE: on `out_ready` (K moves into M); no input is accepted while FULL.
  - `in_ready = (state != FULL)`, taken from a register.
  - `out_valid = (state != EMPTY)`.
- A transfer occurs on a cycle where valid && ready are both 1. While `out_valid && !out_ready`, every `out_*` must hold stable.
- `flush=1`: next state is EMPTY and any input accepted in that same cycle is dropped. `flush` has priority over everything except `rst`.

## Timing
- Reset (asynchronous): state EMPTY, all `out_*` 0, `out_valid=0`, `in_ready=1` (SKID=0: also 1).
- Latency: an instruction accepted in cycle N is presented with `out_valid=1` in cycle N+1.
- Throughput: 1 instruction per cycle while `out_ready=1`.
- With `out_ready` held 0, exactly two instructions are accepted (SKID=1) before `in_ready` goes to 0 in the cycle after the second accept.
- FULL with `out_ready=1` in cycle N: K is presented in N+1 and `in_ready=1` in N+1.
- Flush in cycle N: `out_valid=0` and `in_ready=1` in N+1.
- Reset asserted mid-transfer: outputs clear immediately (no clock edge needed); nothing is retained after reset deasserts.
- Order is strictly FIFO: no entry is reordered, duplicated or lost except by `flush`.

## Test plan
- `addi x1,x2,-1` (0xFFF10093), PC 0x100 → next cycle: rd=1, rs1=2, rs2=0, funct3=0, imm=0xFFFFFFFF, fmt=1, rd_we=1, pc=0x100.
- `sw x5,8(x6)` (0x00532423) → rs1=6, rs2=5, rd=0, funct3=2, imm=8, fmt=2, rd_we=0. `beq x0,x0,-4` (0xFE000EE3) → imm=0xFFFFFFFC, fmt=3.
- `lui x3,0x12345` (0x123451B7) → rd=3, imm=0x12345000, fmt=4, funct3=0. Word 0xFFFFFFFF → illegal=1, fmt=7, all fields 0.
- Backpressure: `out_ready=0`, push A, B, C back-to-back → A and B accepted, `in_ready=0` from the cycle after B, C held at input. Release `out_ready` → A, B, C emerge in order, with no bubble after the FULL to ONE transition.
- Flush in state FULL with `in_valid=1` on the same cycle → next cycle `out_valid=0`, `in_ready=1`, and the input word never appears at the output.
- Assert `rst` asynchronously while in state ONE → all outputs 0 before the next edge. After release, the first accepted word decodes correctly.
